// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, field bit positions, exception codes.
package cp0_defs;

    // CP0 register numbers
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // Field bit positions within SR and Cause
    localparam int IM_HI   = 15;
    localparam int IM_LO   = 10;
    localparam int EXL     = 1;
    localparam int IE      = 0;
    localparam int BD      = 31;
    localparam int CODE_HI = 6;
    localparam int CODE_LO = 2;

    // Exception codes carried down the pipe
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // EPC always holds a word-aligned address
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/cp0_exc_arbiter.sv
// Combinational interrupt/exception arbiter: decides whether the MEM-stage
// instruction is flushed this cycle and which ExcCode gets recorded.
module cp0_exc_arbiter
    import cp0_defs::*;
(
    input  logic [5:0] im,
    input  logic       exl,
    input  logic       ie,
    input  logic [5:0] hw_int,
    input  logic [4:0] exc_code,
    output logic       int_pend,
    output logic       exc_pend,
    output logic       req,
    output logic [4:0] next_code
);

    // Interrupts need an enabled line, global enable, and no handler in progress;
    // interrupts win over synchronous exceptions.
    always_comb begin
        int_pend  = (|(hw_int & im)) & ie & ~exl;
        exc_pend  = (exc_code != 5'd0) & ~exl;
        req       = int_pend | exc_pend;
        next_code = int_pend ? EXC_INT : exc_code;
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 register file (SR, Cause, EPC, PRId) with exception entry, mtc0 and eret.
module cp0_exc_ctrl
    import cp0_defs::*;
#(
    parameter logic [31:0] PRID       = 32'h2019_0007,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  readAddr,
    input  logic [4:0]  writeAddr,
    input  logic [31:0] writeData,
    input  logic        CP0WE,
    input  logic        eret,
    input  logic [31:0] PC,
    input  logic [4:0]  excCode,
    input  logic        bd,
    input  logic [5:0]  HWInt,
    output logic        req,
    output logic [31:0] excPC,
    output logic [31:0] EPC,
    output logic [31:0] readData
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_code;
    logic [31:0] epc_q;

    logic        int_pend;
    logic        exc_pend;
    logic [4:0]  next_code;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    cp0_exc_arbiter u_arbiter (
        .im        (sr_im),
        .exl       (sr_exl),
        .ie        (sr_ie),
        .hw_int    (HWInt),
        .exc_code  (excCode),
        .int_pend  (int_pend),
        .exc_pend  (exc_pend),
        .req       (req),
        .next_code (next_code)
    );

    // Register state: exception entry squashes mtc0/eret; IP tracks HWInt every edge.
    // NOTE: async reset in the sensitivity list and <= for every state update so all
    // registers sample the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_im      <= '0;
            sr_exl     <= 1'b0;
            sr_ie      <= 1'b0;
            cause_bd   <= 1'b0;
            cause_ip   <= '0;
            cause_code <= '0;
            epc_q      <= '0;
        end else begin
            cause_ip <= HWInt;
            if (req) begin
                sr_exl     <= 1'b1;
                cause_code <= next_code;
                cause_bd   <= bd;
                epc_q      <= word_align(bd ? PC - 32'd4 : PC);
            end else begin
                if (CP0WE && writeAddr == REG_SR) begin
                    sr_im  <= writeData[IM_HI:IM_LO];
                    sr_exl <= writeData[EXL];
                    sr_ie  <= writeData[IE];
                end
                if (CP0WE && writeAddr == REG_EPC) begin
                    epc_q <= word_align(writeData);
                end
                // NOTE: placed after the mtc0 write so that, within this block, the
                // later non-blocking assignment to sr_exl wins when both hit SR.
                if (eret) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

    // Assemble architectural register views and the mfc0 read mux.
    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        sr_val                   = '0;
        sr_val[IM_HI:IM_LO]      = sr_im;
        sr_val[EXL]              = sr_exl;
        sr_val[IE]               = sr_ie;
        cause_val                = '0;
        cause_val[BD]            = cause_bd;
        cause_val[IM_HI:IM_LO]   = cause_ip;
        cause_val[CODE_HI:CODE_LO] = cause_code;
        readData = '0;
        case (readAddr)
            REG_SR:    readData = sr_val;
            REG_CAUSE: readData = cause_val;
            REG_EPC:   readData = epc_q;
            REG_PRID:  readData = PRID;
            default:   readData = '0;
        endcase
    end

    // Fetch redirect: handler on exception entry, otherwise EPC for eret.
    assign EPC   = epc_q;
    assign excPC = req ? HANDLER_PC : epc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed self-checking bench for cp0_exc_ctrl with an expected-value queue.
module tb_cp0_exc_ctrl;
    import cp0_defs::*;

    localparam logic [31:0] PRID_V    = 32'h2019_0007;
    localparam logic [31:0] HANDLER_V = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  readAddr;
    logic [4:0]  writeAddr;
    logic [31:0] writeData;
    logic        CP0WE;
    logic        eret;
    logic [31:0] PC;
    logic [4:0]  excCode;
    logic        bd;
    logic [5:0]  HWInt;
    logic        req;
    logic [31:0] excPC;
    logic [31:0] EPC;
    logic [31:0] readData;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    cp0_exc_ctrl #(.PRID(PRID_V), .HANDLER_PC(HANDLER_V)) dut (
        .clk       (clk),
        .reset     (reset),
        .readAddr  (readAddr),
        .writeAddr (writeAddr),
        .writeData (writeData),
        .CP0WE     (CP0WE),
        .eret      (eret),
        .PC        (PC),
        .excCode   (excCode),
        .bd        (bd),
        .HWInt     (HWInt),
        .req       (req),
        .excPC     (excPC),
        .EPC       (EPC),
        .readData  (readData)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] addr, input logic [31:0] v);
        expect_val(tag, v);
        readAddr = addr;
        #1;
        check(readData);
    endtask

    task automatic req_chk(input string tag, input logic v);
        expect_val(tag, {31'b0, v});
        #1;
        check({31'b0, req});
    endtask

    task automatic pc_chk(input string tag, input logic [31:0] v);
        expect_val(tag, v);
        #1;
        check(excPC);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; readAddr = '0; writeAddr = '0; writeData = '0;
        CP0WE = 1'b0; eret = 1'b0; PC = '0; excCode = '0; bd = 1'b0; HWInt = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        req_chk("rst_req", 1'b0);
        pc_chk("rst_excpc", 32'h0);
        rd_chk("rst_sr", REG_SR, 32'h0);
        rd_chk("rst_cause", REG_CAUSE, 32'h0);
        rd_chk("rst_epc", REG_EPC, 32'h0);
        rd_chk("rst_prid", REG_PRID, PRID_V);
        rd_chk("rst_unmapped", 5'd20, 32'h0);

        // mtc0 SR = 0xFC01
        CP0WE = 1'b1; writeAddr = REG_SR; writeData = 32'h0000_FC01;
        req_chk("mtc0_sr_req", 1'b0);
        tick();
        CP0WE = 1'b0;
        rd_chk("sr_written", REG_SR, 32'h0000_FC01);

        // Interrupt on line 4
        HWInt = 6'b000100; PC = 32'h3010; bd = 1'b0;
        req_chk("int_req", 1'b1);
        pc_chk("int_excpc", HANDLER_V);
        tick();
        HWInt = 6'b0;
        req_chk("int_exl_req", 1'b0);
        pc_chk("int_excpc_epc", 32'h3010);
        rd_chk("int_epc", REG_EPC, 32'h3010);
        rd_chk("int_cause", REG_CAUSE, 32'h0000_1000);
        rd_chk("int_sr", REG_SR, 32'h0000_FC03);

        // Overflow in delay slot
        CP0WE = 1'b1; writeAddr = REG_SR; writeData = 32'h0000_0001;
        tick();
        CP0WE = 1'b0;
        excCode = EXC_OV; bd = 1'b1; PC = 32'h3024;
        req_chk("ov_req", 1'b1);
        tick();
        excCode = '0; bd = 1'b0;
        rd_chk("ov_epc", REG_EPC, 32'h3020);
        rd_chk("ov_cause", REG_CAUSE, 32'h8000_0030);
        rd_chk("ov_sr", REG_SR, 32'h0000_0003);

        // EXL blocks both interrupts and exceptions
        excCode = EXC_RI; HWInt = 6'h3F;
        req_chk("exl_block_req", 1'b0);
        tick();
        rd_chk("exl_epc_kept", REG_EPC, 32'h3020);
        rd_chk("exl_ip_tracks", REG_CAUSE, 32'h8000_FC30);

        // mtc0 SR plus eret in one cycle: write then EXL cleared
        CP0WE = 1'b1; writeAddr = REG_SR; writeData = 32'h0000_FC03; eret = 1'b1;
        req_chk("eret_cycle_req", 1'b0);
        tick();
        eret = 1'b0;
        rd_chk("eret_sr", REG_SR, 32'h0000_FC01);

        // Interrupt beats excCode=4 and squashes a concurrent mtc0 EPC
        writeAddr = REG_EPC; writeData = 32'h0000_5000; excCode = EXC_ADEL; PC = 32'h3100;
        req_chk("post_eret_req", 1'b1);
        pc_chk("post_eret_excpc", HANDLER_V);
        tick();
        CP0WE = 1'b0; excCode = '0;
        rd_chk("prio_cause", REG_CAUSE, 32'h0000_FC00);
        rd_chk("mtc0_dropped_epc", REG_EPC, 32'h3100);

        // mtc0 EPC alignment and ignored Cause write
        CP0WE = 1'b1; writeAddr = REG_EPC; writeData = 32'h0000_3007;
        tick();
        writeAddr = REG_CAUSE; writeData = 32'hFFFF_FFFF;
        rd_chk("epc_aligned", REG_EPC, 32'h3004);
        pc_chk("excpc_is_epc", 32'h3004);
        tick();
        CP0WE = 1'b0;
        rd_chk("cause_unwritable", REG_CAUSE, 32'h0000_FC00);

        // Async reset mid-handler, then immediate exception after release
        excCode = EXC_ADES;
        reset = 1'b1;
        rd_chk("async_rst_sr", REG_SR, 32'h0);
        rd_chk("async_rst_cause", REG_CAUSE, 32'h0);
        rd_chk("async_rst_epc", REG_EPC, 32'h0);
        reset = 1'b0; PC = 32'h3200;
        req_chk("rst_release_req", 1'b1);
        tick();
        excCode = '0;
        rd_chk("rst_release_cause", REG_CAUSE, 32'h0000_FC14);
        rd_chk("rst_release_epc", REG_EPC, 32'h3200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
